// File: rtl/multi_cycle_ctrl.sv
// ---------------------------------------------------------------------------
// multi_cycle_ctrl
//   Main control FSM of the multicycle CPU. Sequences fetch, decode, execute,
//   memory and write-back for each instruction, decodes the opcode held in IR,
//   stretches memory states on the mem_ready handshake and counts retired
//   instructions.
//
//   Build option: define CTRL_ADDI_EN to decode addi (opcode 001000) through
//   the IEX/IWB states. Without it those states are not built and addi is
//   handled as an undecodable opcode.
//
// Ports
//   i_clk          system clock, rising edge
//   i_rst_n        asynchronous active-low reset
//   i_Op           IR[31:26], valid from ID onward
//   i_mem_ready    memory access completes this cycle
//   o_PCWrite      unconditional PC write enable
//   o_PCWriteCond  conditional (branch) PC write enable
//   o_PCSource     00 ALU result, 01 ALUOut, 10 jump address
//   o_BEQorBNE     1 = beq, 0 = bne
//   o_IorD         memory address select (0 PC, 1 ALUOut)
//   o_MemRead      memory read strobe
//   o_MemWrite     memory write strobe
//   o_IRWrite      instruction register load
//   o_MemtoReg     register write data from memory
//   o_RegDst       destination register = rd
//   o_RegWrite     register file write enable
//   o_ALUSrcA      ALU A = register A (else PC)
//   o_ALUSrcB      00 reg B, 01 const 4, 10 imm, 11 imm<<2
//   o_ALUOp        00 add, 01 sub, 10 funct-decoded
//   o_illegal      one-cycle pulse in ID for an undecodable opcode
//   o_retired      instructions completed since reset, wraps
// ---------------------------------------------------------------------------
module multi_cycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [5:0]       i_Op,
  input  logic             i_mem_ready,
  output logic             o_PCWrite,
  output logic             o_PCWriteCond,
  output logic [1:0]       o_PCSource,
  output logic             o_BEQorBNE,
  output logic             o_IorD,
  output logic             o_MemRead,
  output logic             o_MemWrite,
  output logic             o_IRWrite,
  output logic             o_MemtoReg,
  output logic             o_RegDst,
  output logic             o_RegWrite,
  output logic             o_ALUSrcA,
  output logic [1:0]       o_ALUSrcB,
  output logic [1:0]       o_ALUOp,
  output logic             o_illegal,
  output logic [CNT_W-1:0] o_retired
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  typedef enum logic [3:0] {
    S_RST,
    S_IF,
    S_ID,
    S_MADDR,
    S_MRD,
    S_MWB,
    S_MWR,
    S_REX,
    S_RWB,
    S_BR,
    S_JMP
`ifdef CTRL_ADDI_EN
    ,
    S_IEX,
    S_IWB
`endif
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             w_retire;
  logic [CNT_W-1:0] r_retired;

  // Next-state and retirement decode. Every instruction-final state returns
  // to IF, and that transition is what counts as a retirement; the illegal
  // path (ID -> IF) deliberately does not retire.
  always_comb begin
    w_next   = r_state;
    w_retire = 1'b0;
    case (r_state)
      S_RST:   w_next = S_IF;
      S_IF:    if (i_mem_ready) w_next = S_ID;
      S_ID: begin
        case (i_Op)
          OP_LW, OP_SW:   w_next = S_MADDR;
          OP_RTYPE:       w_next = S_REX;
          OP_BEQ, OP_BNE: w_next = S_BR;
          OP_J:           w_next = S_JMP;
`ifdef CTRL_ADDI_EN
          OP_ADDI:        w_next = S_IEX;
`endif
          default:        w_next = S_IF;
        endcase
      end
      S_MADDR: w_next = (i_Op == OP_SW) ? S_MWR : S_MRD;
      S_MRD:   if (i_mem_ready) w_next = S_MWB;
      S_MWR: begin
        if (i_mem_ready) begin
          w_next   = S_IF;
          w_retire = 1'b1;
        end
      end
      S_REX:   w_next = S_RWB;
`ifdef CTRL_ADDI_EN
      S_IEX:   w_next = S_IWB;
      S_IWB: begin
        w_next   = S_IF;
        w_retire = 1'b1;
      end
`endif
      S_MWB, S_RWB, S_BR, S_JMP: begin
        w_next   = S_IF;
        w_retire = 1'b1;
      end
      default: w_next = S_RST;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_RST;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      if (w_retire) r_retired <= r_retired + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Moore decode from the state register. Because the reset clears the state
  // asynchronously, every enable drops the moment rst_n falls. IF is the only
  // state whose enables also look at an input: PC and IR load only when the
  // fetch actually completes.
  always_comb begin
    o_PCWrite     = 1'b0;
    o_PCWriteCond = 1'b0;
    o_PCSource    = 2'b00;
    o_BEQorBNE    = 1'b0;
    o_IorD        = 1'b0;
    o_MemRead     = 1'b0;
    o_MemWrite    = 1'b0;
    o_IRWrite     = 1'b0;
    o_MemtoReg    = 1'b0;
    o_RegDst      = 1'b0;
    o_RegWrite    = 1'b0;
    o_ALUSrcA     = 1'b0;
    o_ALUSrcB     = 2'b00;
    o_ALUOp       = 2'b00;
    o_illegal     = 1'b0;
    case (r_state)
      S_IF: begin
        o_MemRead = 1'b1;
        o_ALUSrcB = 2'b01;
        o_PCWrite = i_mem_ready;
        o_IRWrite = i_mem_ready;
      end
      S_ID: begin
        // ALU precomputes the branch target into ALUOut while decoding.
        o_ALUSrcB = 2'b11;
        case (i_Op)
          OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_BNE, OP_J: o_illegal = 1'b0;
`ifdef CTRL_ADDI_EN
          OP_ADDI:                                      o_illegal = 1'b0;
`endif
          default:                                      o_illegal = 1'b1;
        endcase
      end
      S_MADDR: begin
        o_ALUSrcA = 1'b1;
        o_ALUSrcB = 2'b10;
      end
      S_MRD: begin
        o_MemRead = 1'b1;
        o_IorD    = 1'b1;
      end
      S_MWB: begin
        o_RegWrite = 1'b1;
        o_MemtoReg = 1'b1;
      end
      S_MWR: begin
        o_MemWrite = 1'b1;
        o_IorD     = 1'b1;
      end
      S_REX: begin
        o_ALUSrcA = 1'b1;
        o_ALUOp   = 2'b10;
      end
      S_RWB: begin
        o_RegWrite = 1'b1;
        o_RegDst   = 1'b1;
      end
      S_BR: begin
        o_ALUSrcA     = 1'b1;
        o_ALUOp       = 2'b01;
        o_PCWriteCond = 1'b1;
        o_PCSource    = 2'b01;
        // Op[0] distinguishes bne (000101) from beq (000100).
        o_BEQorBNE    = ~i_Op[0];
      end
      S_JMP: begin
        o_PCWrite  = 1'b1;
        o_PCSource = 2'b10;
      end
`ifdef CTRL_ADDI_EN
      S_IEX: begin
        o_ALUSrcA = 1'b1;
        o_ALUSrcB = 2'b10;
      end
      S_IWB: begin
        o_RegWrite = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign o_retired = r_retired;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
module tb_multi_cycle_ctrl;

  localparam int CNT_W = 32;
`ifdef CTRL_ADDI_EN
  localparam bit ADDI = 1'b1;
`else
  localparam bit ADDI = 1'b0;
`endif

  // Instruction phases as named by the control description.
  localparam int P_RST = 0, P_IF = 1, P_ID = 2, P_MADDR = 3, P_MRD = 4,
                 P_MWB = 5, P_MWR = 6, P_REX = 7, P_RWB = 8, P_BR = 9,
                 P_JMP = 10, P_IEX = 11, P_IWB = 12;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [5:0]       op = 6'b0;
  logic             mr = 1'b0;
  logic             w_PCWrite, w_PCWriteCond, w_BEQorBNE, w_IorD, w_MemRead;
  logic             w_MemWrite, w_IRWrite, w_MemtoReg, w_RegDst, w_RegWrite;
  logic             w_ALUSrcA, w_illegal;
  logic [1:0]       w_PCSource, w_ALUSrcB, w_ALUOp;
  logic [CNT_W-1:0] w_retired;
  logic [17:0]      w_obs;

  int n_chk  = 0;
  int n_fail = 0;
  logic [CNT_W-1:0] exp_retired = '0;

  always #5 clk = ~clk;

  multi_cycle_ctrl #(.CNT_W(CNT_W)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_Op(op), .i_mem_ready(mr),
    .o_PCWrite(w_PCWrite), .o_PCWriteCond(w_PCWriteCond), .o_PCSource(w_PCSource),
    .o_BEQorBNE(w_BEQorBNE), .o_IorD(w_IorD), .o_MemRead(w_MemRead),
    .o_MemWrite(w_MemWrite), .o_IRWrite(w_IRWrite), .o_MemtoReg(w_MemtoReg),
    .o_RegDst(w_RegDst), .o_RegWrite(w_RegWrite), .o_ALUSrcA(w_ALUSrcA),
    .o_ALUSrcB(w_ALUSrcB), .o_ALUOp(w_ALUOp), .o_illegal(w_illegal),
    .o_retired(w_retired)
  );

  assign w_obs = {w_PCWrite, w_PCWriteCond, w_PCSource, w_BEQorBNE, w_IorD,
                  w_MemRead, w_MemWrite, w_IRWrite, w_MemtoReg, w_RegDst,
                  w_RegWrite, w_ALUSrcA, w_ALUSrcB, w_ALUOp, w_illegal};

  function automatic bit is_legal(input logic [5:0] o);
    return (o == 6'b100011) || (o == 6'b101011) || (o == 6'b000000) ||
           (o == 6'b000100) || (o == 6'b000101) || (o == 6'b000010) ||
           (ADDI && o == 6'b001000);
  endfunction

  // Expected control word for a phase, in the same bit order as w_obs.
  function automatic logic [17:0] exp_out(input int ph, input logic [5:0] o, input logic m);
    logic pcw, pcwc, beq, iord, mrd, mwr, irw, m2r, rdst, rw, asa, ill;
    logic [1:0] pcs, asb, aop;
    {pcw, pcwc, beq, iord, mrd, mwr, irw, m2r, rdst, rw, asa, ill} = '0;
    pcs = 2'b00; asb = 2'b00; aop = 2'b00;
    case (ph)
      P_IF:    begin mrd = 1; asb = 2'b01; pcw = m; irw = m; end
      P_ID:    begin asb = 2'b11; ill = !is_legal(o); end
      P_MADDR: begin asa = 1; asb = 2'b10; end
      P_MRD:   begin mrd = 1; iord = 1; end
      P_MWB:   begin rw = 1; m2r = 1; end
      P_MWR:   begin mwr = 1; iord = 1; end
      P_REX:   begin asa = 1; aop = 2'b10; end
      P_RWB:   begin rw = 1; rdst = 1; end
      P_BR:    begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; beq = ~o[0]; end
      P_JMP:   begin pcw = 1; pcs = 2'b10; end
      P_IEX:   begin asa = 1; asb = 2'b10; end
      P_IWB:   begin rw = 1; end
      default: ;
    endcase
    return {pcw, pcwc, pcs, beq, iord, mrd, mwr, irw, m2r, rdst, rw, asa, asb, aop, ill};
  endfunction

  task automatic check_word(input string tag, input logic [17:0] exp);
    n_chk++;
    assert (w_obs === exp) else begin
      n_fail++;
      $error("FAIL %s ctrl obs=%b exp=%b t=%0t", tag, w_obs, exp, $time);
    end
  endtask

  task automatic check_ret(input string tag);
    n_chk++;
    assert (w_retired === exp_retired) else begin
      n_fail++;
      $error("FAIL %s retired obs=%0d exp=%0d t=%0t", tag, w_retired, exp_retired, $time);
    end
  endtask

  // Runs one instruction from its first IF cycle; called just after a rising
  // edge. s_if / s_mem are wait cycles in fetch and in the data access.
  // abort_at >= 0 pulses reset after that cycle's checks.
  task automatic run_instr(input logic [5:0] o, input int s_if, input int s_mem,
                           input int abort_at);
    int ph_q[$];
    int mr_q[$];
    logic [5:0] prev_op;
    prev_op = op;
    for (int i = 0; i < s_if; i++) begin ph_q.push_back(P_IF); mr_q.push_back(0); end
    ph_q.push_back(P_IF); mr_q.push_back(1);
    ph_q.push_back(P_ID); mr_q.push_back(-1);
    if (is_legal(o)) begin
      case (o)
        6'b100011: begin
          ph_q.push_back(P_MADDR); mr_q.push_back(-1);
          for (int i = 0; i < s_mem; i++) begin ph_q.push_back(P_MRD); mr_q.push_back(0); end
          ph_q.push_back(P_MRD); mr_q.push_back(1);
          ph_q.push_back(P_MWB); mr_q.push_back(-1);
        end
        6'b101011: begin
          ph_q.push_back(P_MADDR); mr_q.push_back(-1);
          for (int i = 0; i < s_mem; i++) begin ph_q.push_back(P_MWR); mr_q.push_back(0); end
          ph_q.push_back(P_MWR); mr_q.push_back(1);
        end
        6'b000000: begin ph_q.push_back(P_REX); mr_q.push_back(-1);
                         ph_q.push_back(P_RWB); mr_q.push_back(-1); end
        6'b000100, 6'b000101: begin ph_q.push_back(P_BR); mr_q.push_back(-1); end
        6'b000010: begin ph_q.push_back(P_JMP); mr_q.push_back(-1); end
        default:   begin ph_q.push_back(P_IEX); mr_q.push_back(-1);
                         ph_q.push_back(P_IWB); mr_q.push_back(-1); end
      endcase
    end
    for (int c = 0; c < ph_q.size(); c++) begin
      mr = (mr_q[c] < 0) ? 1'($urandom_range(0, 1)) : 1'(mr_q[c]);
      op = (c <= s_if) ? prev_op : o;
      @(negedge clk);
      check_word($sformatf("op%b_c%0d", o, c), exp_out(ph_q[c], op, mr));
      check_ret($sformatf("op%b_c%0d", o, c));
      if (c == abort_at) begin
        rst_n = 1'b0;
        #1;
        exp_retired = '0;
        check_word("abort_now", '0);
        check_ret("abort_now");
        @(posedge clk); #1;
        check_word("abort_held", '0);
        rst_n = 1'b1;
        @(negedge clk);
        check_word("abort_rst_state", '0);
        check_ret("abort_rst_state");
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
    end
    if (is_legal(o)) exp_retired++;
  endtask

  logic [5:0] op_tab [8] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                             6'b000101, 6'b000010, 6'b001000, 6'b111111};

  initial begin
    logic [5:0] rop;
    // Reset asserted from time zero: outputs and counter clear without a clock edge.
    #2;
    check_word("reset_async", '0);
    check_ret("reset_async");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_word("rst_state", '0);
    check_ret("rst_state");
    @(posedge clk); #1;

    // Directed instructions.
    run_instr(6'b000000, 0, 0, -1);   // R-type
    run_instr(6'b100011, 0, 3, -1);   // lw, three memory waits
    run_instr(6'b000100, 0, 0, -1);   // beq
    run_instr(6'b000101, 1, 0, -1);   // bne, one fetch wait
    run_instr(6'b000010, 0, 0, -1);   // j
    run_instr(6'b111111, 0, 0, -1);   // undecodable
    run_instr(6'b001000, 0, 0, -1);   // addi (build dependent)
    run_instr(6'b101011, 2, 2, -1);   // sw with waits

    // Randomized instruction stream.
    for (int k = 0; k < 60; k++) begin
      int sel;
      sel = $urandom_range(0, 8);
      rop = (sel == 8) ? 6'($urandom_range(0, 63)) : op_tab[sel];
      run_instr(rop, $urandom_range(0, 3), $urandom_range(0, 3), -1);
    end

    // sw aborted by reset while waiting in its write access (cycle index 4).
    run_instr(6'b101011, 0, 3, 4);
    run_instr(6'b000000, 0, 0, -1);
    run_instr(6'b100011, 1, 1, -1);
    @(negedge clk);
    check_ret("final");

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
